// File: rtl/trap_sequencer_if.sv
// Trap sequencer bus interface: exception codes and PCs from the pipeline
// in, CSR write strobes, PC redirect and permission flags out.
// The master side is the pipeline/CSR environment, the slave side is the
// trap_sequencer itself.
// Optional macro TRAP_SEQUENCER_MTVAL_EN adds the mtval write channel.
// Shared width and exception-code encodings are defined here, guarded, so
// every file of the block sees the same values.

`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

`ifndef NO_E
`define NO_E                     4'hF
`endif
`ifndef E_FETCH_ADDR_MISALIGNED
`define E_FETCH_ADDR_MISALIGNED  4'd0
`endif
`ifndef E_FETCH_ACCESS_FAULT
`define E_FETCH_ACCESS_FAULT     4'd1
`endif
`ifndef E_ILLEGAL_INSTR
`define E_ILLEGAL_INSTR          4'd2
`endif
`ifndef E_BREAKPOINT
`define E_BREAKPOINT             4'd3
`endif
`ifndef E_LOAD_ADDR_MISALIGNED
`define E_LOAD_ADDR_MISALIGNED   4'd4
`endif
`ifndef E_LOAD_ACCESS_FAULT
`define E_LOAD_ACCESS_FAULT      4'd5
`endif
`ifndef E_STORE_ADDR_MISALIGNED
`define E_STORE_ADDR_MISALIGNED  4'd6
`endif
`ifndef E_STORE_ADDR_FAULT
`define E_STORE_ADDR_FAULT       4'd7
`endif
`ifndef E_ECALL
`define E_ECALL                  4'd11
`endif

interface trap_sequencer_if #(
    parameter int W = 64
);
    logic [3:0]   i_exception_code_f;
    logic [3:0]   i_exception_code_e;
    logic [W-1:0] i_pc_f;
    logic [W-1:0] i_pc_e;
    logic [W-1:0] i_alu_out_e;
    logic         i_mret_e;
    logic [W-1:0] i_mepc_csr;

    logic         o_flush;
    logic         o_redirect_valid;
    logic [W-1:0] o_redirect_pc;
    logic         o_mcause_we;
    logic         o_mepc_we;
    logic [3:0]   o_mcause;
    logic [W-1:0] o_mepc;
    logic         o_reset_permission;
    logic         o_trap_permission;
    logic         o_halt;
`ifdef TRAP_SEQUENCER_MTVAL_EN
    logic [W-1:0] o_mtval;
    logic         o_mtval_we;
`endif

    modport master (
        output i_exception_code_f, i_exception_code_e, i_pc_f, i_pc_e,
               i_alu_out_e, i_mret_e, i_mepc_csr,
        input  o_flush, o_redirect_valid, o_redirect_pc, o_mcause_we,
               o_mepc_we, o_mcause, o_mepc, o_reset_permission,
               o_trap_permission, o_halt
`ifdef TRAP_SEQUENCER_MTVAL_EN
        , input o_mtval, o_mtval_we
`endif
    );

    modport slave (
        input  i_exception_code_f, i_exception_code_e, i_pc_f, i_pc_e,
               i_alu_out_e, i_mret_e, i_mepc_csr,
        output o_flush, o_redirect_valid, o_redirect_pc, o_mcause_we,
               o_mepc_we, o_mcause, o_mepc, o_reset_permission,
               o_trap_permission, o_halt
`ifdef TRAP_SEQUENCER_MTVAL_EN
        , output o_mtval, o_mtval_we
`endif
    );
endinterface

// File: rtl/trap_sequencer.sv
// Trap sequencer: picks the oldest pending exception, flushes F/D/E, writes
// mcause/mepc, redirects to the trap vector and handles mret. Owns the
// reset-region and trap-region execution permission flags.
// Optional macro TRAP_SEQUENCER_MTVAL_EN adds the mtval register and
// its write strobe; without it the mtval path is absent entirely.

module trap_sequencer #(
    parameter int                  XLEN        = `XLEN_64b,
    parameter int                  PC_WIDTH    = 1 << (XLEN + 4),
    parameter logic [PC_WIDTH-1:0] TRAP_VECTOR = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    trap_sequencer_if.slave  bus
);

    // Bits 20:18 of the fetch PC identify the code region being fetched.
    localparam logic [2:0] TEXT_REGION = 3'b010;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_RUN,
        ST_FLUSH,
        ST_SAVE,
        ST_ENTER,
        ST_IN_TRAP,
        ST_RETURN,
        ST_HALT
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic                exc_f;
    logic                exc_e;
    logic                exc_any;
    logic [3:0]          sel_cause;
    logic [PC_WIDTH-1:0] sel_epc;
    logic [3:0]          cause_q;
    logic [PC_WIDTH-1:0] epc_q;

    // Exception detection and oldest-first selection (execute is older).
    always_comb begin
        exc_f     = (bus.i_exception_code_f != `NO_E);
        exc_e     = (bus.i_exception_code_e != `NO_E);
        exc_any   = exc_f || exc_e;
        sel_cause = exc_e ? bus.i_exception_code_e : bus.i_exception_code_f;
        sel_epc   = exc_e ? bus.i_pc_e : bus.i_pc_f;
    end

    // State register; reset is synchronous and wins from any state.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (i_rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture cause and faulting PC when a trap is accepted in RUN.
    always_ff @(posedge i_clk) begin
        // NOTE: these data registers are not reset; they are only driven
        // onto the CSR bus in SAVE, which is always preceded by a capture.
        if (state_q == ST_RUN && exc_any) begin
            cause_q <= sel_cause;
            epc_q   <= sel_epc;
        end
    end

`ifdef TRAP_SEQUENCER_MTVAL_EN
    logic [PC_WIDTH-1:0] sel_mtval;
    logic [PC_WIDTH-1:0] mtval_q;

    // mtval source: data address for load/store faults, PC for fetch faults.
    always_comb begin
        sel_mtval = '0;
        case (sel_cause)
            `E_LOAD_ADDR_MISALIGNED,
            `E_LOAD_ACCESS_FAULT,
            `E_STORE_ADDR_MISALIGNED,
            `E_STORE_ADDR_FAULT:      sel_mtval = bus.i_alu_out_e;
            `E_FETCH_ADDR_MISALIGNED,
            `E_FETCH_ACCESS_FAULT:    sel_mtval = sel_epc;
            default:                  sel_mtval = '0;
        endcase
    end

    // mtval is latched on the same edge as cause and epc.
    always_ff @(posedge i_clk) begin
        if (state_q == ST_RUN && exc_any) begin
            mtval_q <= sel_mtval;
        end
    end
`else
    // The execute address only feeds mtval, which this build omits.
    logic unused_alu_out;
    assign unused_alu_out = ^bus.i_alu_out_e;
`endif

    // Next-state and Moore outputs; CSR strobes and redirects are single
    // cycle because each lives in a one-cycle state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // signal unassigned and infers a latch.
        state_d                = state_q;
        bus.o_flush            = 1'b0;
        bus.o_redirect_valid   = 1'b0;
        bus.o_redirect_pc      = '0;
        bus.o_mcause_we        = 1'b0;
        bus.o_mepc_we          = 1'b0;
        bus.o_mcause           = '0;
        bus.o_mepc             = '0;
        bus.o_reset_permission = 1'b0;
        bus.o_trap_permission  = 1'b0;
        bus.o_halt             = 1'b0;
`ifdef TRAP_SEQUENCER_MTVAL_EN
        bus.o_mtval            = '0;
        bus.o_mtval_we         = 1'b0;
`endif

        case (state_q)
            ST_BOOT: begin
                bus.o_reset_permission = 1'b1;
                if (exc_any) begin
                    state_d = ST_HALT;
                end else if (bus.i_pc_f[20:18] == TEXT_REGION) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (exc_any) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                bus.o_flush = 1'b1;
                state_d     = ST_SAVE;
            end
            ST_SAVE: begin
                bus.o_flush     = 1'b1;
                bus.o_mcause_we = 1'b1;
                bus.o_mepc_we   = 1'b1;
                bus.o_mcause    = cause_q;
                bus.o_mepc      = epc_q;
`ifdef TRAP_SEQUENCER_MTVAL_EN
                bus.o_mtval_we  = 1'b1;
                bus.o_mtval     = mtval_q;
`endif
                state_d         = ST_ENTER;
            end
            ST_ENTER: begin
                bus.o_redirect_valid  = 1'b1;
                bus.o_redirect_pc     = TRAP_VECTOR;
                bus.o_trap_permission = 1'b1;
                state_d               = ST_IN_TRAP;
            end
            ST_IN_TRAP: begin
                bus.o_trap_permission = 1'b1;
                if (exc_any) begin
                    state_d = ST_HALT;
                end else if (bus.i_mret_e) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                bus.o_flush           = 1'b1;
                bus.o_redirect_valid  = 1'b1;
                bus.o_redirect_pc     = bus.i_mepc_csr;
                bus.o_trap_permission = 1'b1;
                state_d               = ST_RUN;
            end
            ST_HALT: begin
                bus.o_flush = 1'b1;
                bus.o_halt  = 1'b1;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer. Each test task drives one cycle
// of inputs at a time and pushes the outputs expected for that cycle onto a
// scoreboard; a negedge monitor pops and compares them.

`ifndef XLEN_64b
`define XLEN_64b 2
`endif
`ifndef NO_E
`define NO_E                     4'hF
`endif
`ifndef E_FETCH_ADDR_MISALIGNED
`define E_FETCH_ADDR_MISALIGNED  4'd0
`endif
`ifndef E_FETCH_ACCESS_FAULT
`define E_FETCH_ACCESS_FAULT     4'd1
`endif
`ifndef E_ILLEGAL_INSTR
`define E_ILLEGAL_INSTR          4'd2
`endif
`ifndef E_LOAD_ADDR_MISALIGNED
`define E_LOAD_ADDR_MISALIGNED   4'd4
`endif
`ifndef E_LOAD_ACCESS_FAULT
`define E_LOAD_ACCESS_FAULT      4'd5
`endif
`ifndef E_STORE_ADDR_FAULT
`define E_STORE_ADDR_FAULT       4'd7
`endif
`ifndef E_ECALL
`define E_ECALL                  4'd11
`endif

module tb_trap_sequencer;
    localparam int W = 64;

    logic clk = 1'b1;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trap_sequencer_if #(.W(W)) bus ();

    trap_sequencer #(
        .XLEN     (`XLEN_64b),
        .PC_WIDTH (W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic         flush;
        logic         rv;
        logic [W-1:0] rpc;
        logic         cwe;
        logic         ewe;
        logic [3:0]   cause;
        logic [W-1:0] epc;
        logic         rp;
        logic         tp;
        logic         halt;
        logic [W-1:0] mtval;
        logic         twe;
    } snap_t;

    snap_t exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    function automatic snap_t mk(input logic flush, input logic rv,
                                 input logic [W-1:0] rpc, input logic we,
                                 input logic [3:0] cause, input logic [W-1:0] epc,
                                 input logic rp, input logic tp, input logic halt,
                                 input logic [W-1:0] mtval);
        snap_t s;
        s.flush = flush; s.rv = rv; s.rpc = rpc;
        s.cwe = we; s.ewe = we; s.twe = we;
        s.cause = cause; s.epc = epc;
        s.rp = rp; s.tp = tp; s.halt = halt; s.mtval = mtval;
        return s;
    endfunction

    function automatic snap_t s_boot();  return mk(0, 0, '0, 0, 4'd0, '0, 1, 0, 0, '0); endfunction
    function automatic snap_t s_run();   return mk(0, 0, '0, 0, 4'd0, '0, 0, 0, 0, '0); endfunction
    function automatic snap_t s_flush(); return mk(1, 0, '0, 0, 4'd0, '0, 0, 0, 0, '0); endfunction
    function automatic snap_t s_enter(); return mk(0, 1, '0, 0, 4'd0, '0, 0, 1, 0, '0); endfunction
    function automatic snap_t s_trap();  return mk(0, 0, '0, 0, 4'd0, '0, 0, 1, 0, '0); endfunction
    function automatic snap_t s_halt();  return mk(1, 0, '0, 0, 4'd0, '0, 0, 0, 1, '0); endfunction
    function automatic snap_t s_save(input logic [3:0] c, input logic [W-1:0] e,
                                     input logic [W-1:0] t);
        return mk(1, 0, '0, 1, c, e, 0, 0, 0, t);
    endfunction
    function automatic snap_t s_ret(input logic [W-1:0] pc);
        return mk(1, 1, pc, 0, 4'd0, '0, 0, 1, 0, '0);
    endfunction

    // Scoreboard monitor: compare one expected snapshot per cycle at negedge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            snap_t e;
            snap_t a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a.flush = bus.o_flush;         a.rv  = bus.o_redirect_valid;
            a.rpc   = bus.o_redirect_pc;   a.cwe = bus.o_mcause_we;
            a.ewe   = bus.o_mepc_we;       a.cause = bus.o_mcause;
            a.epc   = bus.o_mepc;          a.rp  = bus.o_reset_permission;
            a.tp    = bus.o_trap_permission; a.halt = bus.o_halt;
`ifdef TRAP_SEQUENCER_MTVAL_EN
            a.mtval = bus.o_mtval;         a.twe = bus.o_mtval_we;
`else
            a.mtval = e.mtval;             a.twe = e.twe;
`endif
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got fl=%b rv=%b rpc=%h we=%b%b%b cause=%h epc=%h rp=%b tp=%b halt=%b mtval=%h; expected fl=%b rv=%b rpc=%h we=%b%b%b cause=%h epc=%h rp=%b tp=%b halt=%b mtval=%h",
                         nm, a.flush, a.rv, a.rpc, a.cwe, a.ewe, a.twe, a.cause, a.epc,
                         a.rp, a.tp, a.halt, a.mtval,
                         e.flush, e.rv, e.rpc, e.cwe, e.ewe, e.twe, e.cause, e.epc,
                         e.rp, e.tp, e.halt, e.mtval);
            end
        end
    end

    task automatic drive(input logic [3:0] cf, input logic [3:0] ce,
                         input logic [W-1:0] pcf, input logic [W-1:0] pce,
                         input logic [W-1:0] alu, input logic mret);
        bus.i_exception_code_f = cf;
        bus.i_exception_code_e = ce;
        bus.i_pc_f             = pcf;
        bus.i_pc_e             = pce;
        bus.i_alu_out_e        = alu;
        bus.i_mret_e           = mret;
    endtask

    task automatic idle();
        drive(`NO_E, `NO_E, 64'h80004, 64'h80008, '0, 1'b0);
    endtask

    // Push this cycle's expectation, then advance to just after the next edge.
    task automatic cyc(input string nm, input snap_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic return_from_trap(input logic [W-1:0] target);
        bus.i_mepc_csr = target;
        drive(`NO_E, `NO_E, 64'h00004, 64'h00008, '0, 1'b1);
        cyc("mret_in_trap", s_trap());
        idle();
        cyc("mret_return", s_ret(target));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_mepc_csr = '0;
        drive(`NO_E, `NO_E, 64'h40000, 64'h40000, '0, 1'b0);
        @(posedge clk);
        #1;
        total++;
        if (bus.o_reset_permission !== 1'b1 || bus.o_halt !== 1'b0) begin
            bad++;
            $display("FAIL reset_inline: got rp=%b halt=%b, expected rp=1 halt=0",
                     bus.o_reset_permission, bus.o_halt);
        end
        cyc("reset_state", s_boot());
    endtask

    task automatic test_boot();
        rst = 1'b0;
        drive(`NO_E, `NO_E, 64'h40000, 64'h40000, '0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("boot_reset_region", s_boot());
        drive(`NO_E, `NO_E, 64'h80000, 64'h40000, '0, 1'b0);
        cyc("boot_text_cycle", s_boot());
        drive(`NO_E, `NO_E, 64'h80004, 64'h80000, '0, 1'b1);
        cyc("boot_exit_run", s_run());
        cyc("mret_ignored_run", s_run());
        idle();
        cyc("run_idle", s_run());
    endtask

    task automatic test_ecall();
        drive(`NO_E, `E_ECALL, 64'h80014, 64'h80010, 64'h1234, 1'b0);
        cyc("ecall_sample", s_run());
        drive(`NO_E, `E_ILLEGAL_INSTR, 64'h80018, 64'h80014, '0, 1'b0);
        cyc("ecall_flush", s_flush());
        idle();
        cyc("ecall_save", s_save(`E_ECALL, 64'h80010, '0));
        cyc("ecall_enter", s_enter());
        cyc("ecall_in_trap", s_trap());
        cyc("ecall_in_trap_hold", s_trap());
    endtask

    task automatic test_mret();
        return_from_trap(64'h80014);
        cyc("mret_back_in_run", s_run());
    endtask

    task automatic test_simultaneous();
        drive(`E_FETCH_ADDR_MISALIGNED, `E_LOAD_ADDR_MISALIGNED,
              64'h80022, 64'h80018, 64'h80019, 1'b0);
        cyc("simul_sample", s_run());
        idle();
        cyc("simul_flush", s_flush());
        cyc("simul_save", s_save(`E_LOAD_ADDR_MISALIGNED, 64'h80018, 64'h80019));
        cyc("simul_enter", s_enter());
        cyc("simul_in_trap", s_trap());
        return_from_trap(64'h8001c);
    endtask

    // The exception lands in the very first RUN cycle after a return.
    task automatic test_back_to_back();
        drive(`E_FETCH_ACCESS_FAULT, `NO_E, 64'h80030, 64'h8002c, 64'h999, 1'b0);
        cyc("b2b_sample", s_run());
        idle();
        cyc("b2b_flush", s_flush());
        cyc("b2b_save", s_save(`E_FETCH_ACCESS_FAULT, 64'h80030, 64'h80030));
        cyc("b2b_enter", s_enter());
        cyc("b2b_in_trap", s_trap());
        return_from_trap(64'h80034);
        cyc("b2b_back_in_run", s_run());
    endtask

    task automatic test_double_fault();
        drive(`NO_E, `E_LOAD_ACCESS_FAULT, 64'h80044, 64'h80040, 64'h00100, 1'b0);
        cyc("ldfault_sample", s_run());
        idle();
        cyc("ldfault_flush", s_flush());
        cyc("ldfault_save", s_save(`E_LOAD_ACCESS_FAULT, 64'h80040, 64'h00100));
        cyc("ldfault_enter", s_enter());
        drive(`NO_E, `E_STORE_ADDR_FAULT, 64'h00008, 64'h80050, 64'h2000, 1'b1);
        cyc("dfault_in_trap", s_trap());
        drive(`NO_E, `E_ECALL, 64'h80000, 64'h80000, '0, 1'b1);
        cyc("halt_0", s_halt());
        idle();
        cyc("halt_1", s_halt());
        cyc("halt_2", s_halt());
        rst = 1'b1;
        cyc("halt_reset_cycle", s_halt());
        rst = 1'b0;
        drive(`NO_E, `NO_E, 64'h40000, 64'h40000, '0, 1'b0);
        cyc("halt_to_boot", s_boot());
    endtask

    task automatic test_reset_mid_save();
        drive(`NO_E, `NO_E, 64'h80000, 64'h40000, '0, 1'b0);
        cyc("rsave_boot", s_boot());
        drive(`NO_E, `E_ECALL, 64'h80064, 64'h80060, '0, 1'b0);
        cyc("rsave_sample", s_run());
        idle();
        cyc("rsave_flush", s_flush());
        rst = 1'b1;
        cyc("rsave_save", s_save(`E_ECALL, 64'h80060, '0));
        cyc("rsave_reset_held", s_boot());
        rst = 1'b0;
        drive(`NO_E, `NO_E, 64'h40000, 64'h40000, '0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("rsave_no_redirect", s_boot());
    endtask

    task automatic test_boot_exception();
        drive(`E_FETCH_ACCESS_FAULT, `NO_E, 64'h80000, 64'h40000, '0, 1'b0);
        cyc("bootexc_sample", s_boot());
        idle();
        cyc("bootexc_halt", s_halt());
        rst = 1'b1;
        cyc("bootexc_reset_cycle", s_halt());
        rst = 1'b0;
        drive(`NO_E, `NO_E, 64'h40000, 64'h40000, '0, 1'b0);
        cyc("bootexc_boot", s_boot());
    endtask

    initial begin
        test_reset();
        test_boot();
        test_ecall();
        test_mret();
        test_simultaneous();
        test_back_to_back();
        test_double_fault();
        test_reset_mid_save();
        test_boot_exception();
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
